// File: rtl/ring_counter_pkg.sv
// Shared types and helpers for the one-hot ring counter, its monitor and benches.
package ring_counter_pkg;

  typedef enum logic [1:0] {HUNT = 2'd0, CHECK = 2'd1, LOCKED = 2'd2} state_e;

  localparam int RING_WIDTH = 4;
  localparam int MAX_W      = 32;

  // Rotate left within the low w bits: {v[w-2:0], v[w-1]}.
  function automatic logic [MAX_W-1:0] rotl(input logic [MAX_W-1:0] v, input int unsigned w);
    logic [MAX_W-1:0] r;
    r = '0;
    for (int i = 1; i < MAX_W; i++)
      if (i < int'(w)) r[i] = v[i-1];
    r[0] = v[w-1];
    return r;
  endfunction

  // Position of the set bit; OR of positions, so only meaningful for one-hot input.
  function automatic logic [7:0] onehot_to_idx(input logic [MAX_W-1:0] v);
    logic [7:0] r;
    r = '0;
    for (int i = 0; i < MAX_W; i++)
      if (v[i]) r = r | 8'(i);
    return r;
  endfunction

endpackage

// File: rtl/ring_onehot_decode.sv
// Combinational one-hot check and hot-bit index decode of a ring sample.
module ring_onehot_decode #(
  parameter int WIDTH = 4,
  parameter int IDX_W = 2
) (
  input  logic [WIDTH-1:0] q,
  output logic             one_hot,
  output logic [IDX_W-1:0] idx
);
  import ring_counter_pkg::*;

  int unsigned ones;

  always_comb begin
    ones = 0;
    for (int i = 0; i < WIDTH; i++)
      if (q[i]) ones = ones + 1;
    one_hot = (ones == 1);
    idx     = IDX_W'(onehot_to_idx(MAX_W'(q)));
  end

endmodule

// File: rtl/ring_counter_monitor.sv
// Receive-side checker: locks onto the ring rotation and flags illegal codes, skips and stalls.
module ring_counter_monitor #(
  parameter int WIDTH = 4,
  parameter int IDX_W = 2,
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] q_in,
  input  logic             clr_err,
  output logic [IDX_W-1:0] idx,
  output logic             idx_valid,
  output logic             locked,
  output logic             err_pulse,
  output logic             err_sticky,
  output logic [CNT_W-1:0] wrap_count,
  output logic [CNT_W-1:0] err_count
);
  import ring_counter_pkg::*;

  logic             one_hot;
  logic [IDX_W-1:0] dec_idx;

  ring_onehot_decode #(.WIDTH(WIDTH), .IDX_W(IDX_W)) u_dec (
    .q       (q_in),
    .one_hot (one_hot),
    .idx     (dec_idx)
  );

  state_e           state_q, state_d;
  logic [WIDTH-1:0] expected_q, expected_d;
  logic [IDX_W-1:0] idx_q, idx_d;
  logic             idx_valid_q, idx_valid_d;
  logic             locked_q, locked_d;
  logic             err_pulse_q, err_pulse_d;
  logic             err_sticky_q, err_sticky_d;
  logic [CNT_W-1:0] wrap_count_q, wrap_count_d;
  logic [CNT_W-1:0] err_count_q, err_count_d;

  logic [WIDTH-1:0] next_code;
  logic             match, err, wrap;

  always_comb begin
    next_code    = WIDTH'(rotl(MAX_W'(q_in), WIDTH));
    match        = (q_in == expected_q);
    err          = 1'b0;
    wrap         = 1'b0;
    state_d      = state_q;
    expected_d   = expected_q;
    locked_d     = locked_q;
    idx_d        = one_hot ? dec_idx : idx_q;
    idx_valid_d  = one_hot;

    case (state_q)
      HUNT: begin
        if (one_hot) begin
          expected_d = next_code;
          state_d    = CHECK;
        end
      end
      CHECK: begin
        if (match) begin
          expected_d = next_code;
          state_d    = LOCKED;
          locked_d   = 1'b1;
        end else if (one_hot) begin
          expected_d = next_code;
        end else begin
          state_d = HUNT;
        end
      end
      LOCKED: begin
        if (match) begin
          expected_d = next_code;
          // A matched bit 0 means the previous sample was the top stage.
          wrap       = q_in[0];
        end else begin
          err      = 1'b1;
          locked_d = 1'b0;
          if (one_hot) begin
            expected_d = next_code;
            state_d    = CHECK;
          end else begin
            state_d = HUNT;
          end
        end
      end
      default: state_d = HUNT;
    endcase

    err_pulse_d  = err;
    wrap_count_d = (wrap && wrap_count_q != '1) ? wrap_count_q + CNT_W'(1) : wrap_count_q;

    // A same-cycle error beats clr_err, leaving a count of exactly one.
    err_sticky_d = clr_err ? 1'b0 : err_sticky_q;
    err_count_d  = clr_err ? '0 : err_count_q;
    if (err) begin
      err_sticky_d = 1'b1;
      if (clr_err)                 err_count_d = CNT_W'(1);
      else if (err_count_q != '1)  err_count_d = err_count_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= HUNT;
      expected_q   <= '0;
      idx_q        <= '0;
      idx_valid_q  <= 1'b0;
      locked_q     <= 1'b0;
      err_pulse_q  <= 1'b0;
      err_sticky_q <= 1'b0;
      wrap_count_q <= '0;
      err_count_q  <= '0;
    end else begin
      state_q      <= state_d;
      expected_q   <= expected_d;
      idx_q        <= idx_d;
      idx_valid_q  <= idx_valid_d;
      locked_q     <= locked_d;
      err_pulse_q  <= err_pulse_d;
      err_sticky_q <= err_sticky_d;
      wrap_count_q <= wrap_count_d;
      err_count_q  <= err_count_d;
    end
  end

  assign idx        = idx_q;
  assign idx_valid  = idx_valid_q;
  assign locked     = locked_q;
  assign err_pulse  = err_pulse_q;
  assign err_sticky = err_sticky_q;
  assign wrap_count = wrap_count_q;
  assign err_count  = err_count_q;

endmodule

// File: tb/tb_ring_counter_monitor.sv
// Bench for ring_counter_monitor: directed scenarios plus random traffic against an index-level model.
module tb_ring_counter_monitor;
  localparam int W = 4;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic [W-1:0] q_in = '0;
  logic         clr_err = 1'b0;

  logic [1:0] idx_a, idx_b;
  logic       vld_a, vld_b, lk_a, lk_b, ep_a, ep_b, es_a, es_b;
  logic [7:0] wc_a, ec_a;
  logic [1:0] wc_b, ec_b;

  always #5 clk = ~clk;

  ring_counter_monitor #(.WIDTH(W), .IDX_W(2), .CNT_W(8)) dut_a (
    .clk(clk), .rst(rst), .q_in(q_in), .clr_err(clr_err),
    .idx(idx_a), .idx_valid(vld_a), .locked(lk_a), .err_pulse(ep_a),
    .err_sticky(es_a), .wrap_count(wc_a), .err_count(ec_a));

  ring_counter_monitor #(.WIDTH(W), .IDX_W(2), .CNT_W(2)) dut_b (
    .clk(clk), .rst(rst), .q_in(q_in), .clr_err(clr_err),
    .idx(idx_b), .idx_valid(vld_b), .locked(lk_b), .err_pulse(ep_b),
    .err_sticky(es_b), .wrap_count(wc_b), .err_count(ec_b));

  int total = 0;
  int bad   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Model: mode 0=hunting, 1=confirming, 2=locked; exp_i is the index the next sample must hold.
  int m_mode = 0, m_exp = 0, m_idx = 0;
  int m_vld = 0, m_lk = 0, m_ep = 0, m_es = 0;
  int m_wc8 = 0, m_ec8 = 0, m_wc2 = 0, m_ec2 = 0;
  bit started = 0;

  always @(posedge clk) begin
    int  ones, ix;
    bit  oh, e, hit;
    ones = $countones(q_in);
    oh   = (ones == 1);
    ix   = 0;
    for (int i = 0; i < W; i++) if (q_in[i]) ix = i;
    if (rst) begin
      m_mode = 0; m_exp = 0; m_idx = 0; m_vld = 0; m_lk = 0; m_ep = 0; m_es = 0;
      m_wc8 = 0; m_ec8 = 0; m_wc2 = 0; m_ec2 = 0;
    end else begin
      e   = 0;
      hit = oh && (ix == m_exp);
      case (m_mode)
        0: if (oh) begin m_exp = (ix + 1) % W; m_mode = 1; end
        1: if (hit) begin m_exp = (ix + 1) % W; m_mode = 2; m_lk = 1; end
           else if (oh) m_exp = (ix + 1) % W;
           else m_mode = 0;
        default: if (hit) begin
             m_exp = (ix + 1) % W;
             if (ix == 0) begin
               if (m_wc8 < 255) m_wc8++;
               if (m_wc2 < 3)   m_wc2++;
             end
           end else begin
             e = 1; m_lk = 0;
             if (oh) begin m_exp = (ix + 1) % W; m_mode = 1; end
             else m_mode = 0;
           end
      endcase
      if (oh) m_idx = ix;
      m_vld = oh;
      m_ep  = e;
      if (clr_err) begin m_es = 0; m_ec8 = 0; m_ec2 = 0; end
      if (e) begin
        m_es = 1;
        if (clr_err) begin m_ec8 = 1; m_ec2 = 1; end
        else begin
          if (m_ec8 < 255) m_ec8++;
          if (m_ec2 < 3)   m_ec2++;
        end
      end
    end
    started = 1;
  end

  always @(negedge clk) begin
    if (started) begin
      check("idx",        32'(idx_a), 32'(m_idx));
      check("idx_valid",  32'(vld_a), 32'(m_vld));
      check("locked",     32'(lk_a),  32'(m_lk));
      check("err_pulse",  32'(ep_a),  32'(m_ep));
      check("err_sticky", 32'(es_a),  32'(m_es));
      check("wrap_count", 32'(wc_a),  32'(m_wc8));
      check("err_count",  32'(ec_a),  32'(m_ec8));
      check("wrap_sat",   32'(wc_b),  32'(m_wc2));
      check("err_sat",    32'(ec_b),  32'(m_ec2));
      check("locked_b",   32'(lk_b),  32'(m_lk));
    end
  end

  task automatic drive(input logic [W-1:0] q, input logic c = 1'b0, input logic r = 1'b0);
    q_in = q; clr_err = c; rst = r;
    @(posedge clk); #1;
  endtask

  task automatic do_rst();
    drive(4'b0000, 1'b0, 1'b1);
  endtask

  initial begin
    // 1. lock and wrap
    do_rst();
    check("rst_locked", 32'(lk_a), 0);
    check("rst_idx_valid", 32'(vld_a), 0);
    check("rst_err_count", 32'(ec_a), 0);
    drive(4'b0001); check("t1_idx0", 32'(idx_a), 0); check("t1_not_locked", 32'(lk_a), 0);
    drive(4'b0010); check("t1_locked", 32'(lk_a), 1); check("t1_idx1", 32'(idx_a), 1);
    drive(4'b0100); check("t1_idx2", 32'(idx_a), 2);
    drive(4'b1000); check("t1_idx3", 32'(idx_a), 3); check("t1_wrap0", 32'(wc_a), 0);
    drive(4'b0001); check("t1_wrap1", 32'(wc_a), 1); check("t1_idx_wrap", 32'(idx_a), 0);
    check("t1_err0", 32'(ec_a), 0);

    // 2. idle / illegal while hunting
    do_rst();
    repeat (5) drive(4'b0000);
    repeat (2) drive(4'b0110);
    check("t2_locked", 32'(lk_a), 0); check("t2_valid", 32'(vld_a), 0); check("t2_err", 32'(ec_a), 0);

    // 3. violations while locked at 0010
    do_rst();
    drive(4'b0001); drive(4'b0010);
    drive(4'b0101);
    check("t3_ill_pulse", 32'(ep_a), 1); check("t3_ill_cnt", 32'(ec_a), 1);
    check("t3_ill_sticky", 32'(es_a), 1); check("t3_ill_locked", 32'(lk_a), 0);
    drive(4'b0000); check("t3_pulse_once", 32'(ep_a), 0);
    drive(4'b0001); drive(4'b0010);
    drive(4'b1000); check("t3_skip_cnt", 32'(ec_a), 2);
    drive(4'b0001); check("t3_skip_relock", 32'(lk_a), 1);
    drive(4'b0010);
    drive(4'b0010); check("t3_stall_cnt", 32'(ec_a), 3); check("t3_stall_pulse", 32'(ep_a), 1);
    drive(4'b0100); check("t3_relock", 32'(lk_a), 1);
    drive(4'b1000); check("t3_still_locked", 32'(lk_a), 1);

    // 4. clr_err
    drive(4'b0001, 1'b1);
    check("t4_clr_cnt", 32'(ec_a), 0); check("t4_clr_sticky", 32'(es_a), 0);
    check("t4_wrap_kept", 32'(wc_a), 1);
    drive(4'b0000);
    drive(4'b0001); drive(4'b0010);
    drive(4'b0010);
    drive(4'b0100); check("t4_two_errs", 32'(ec_a), 2);
    drive(4'b0100, 1'b1);
    check("t4_err_wins_cnt", 32'(ec_a), 1); check("t4_err_wins_sticky", 32'(es_a), 1);

    // 5. reset mid-lock, and wrap saturation at CNT_W=2
    do_rst();
    for (int k = 0; k < 21; k++) drive(4'(1 << (k % W)));
    check("t5_wrap5", 32'(wc_a), 5); check("t6_wrap_sat", 32'(wc_b), 3);
    drive(4'b0000);
    drive(4'b0001); drive(4'b0010);
    drive(4'b0010);
    drive(4'b0100);
    check("t5_err2", 32'(ec_a), 2); check("t5_locked", 32'(lk_a), 1);
    do_rst();
    check("t5_rst_wrap", 32'(wc_a), 0); check("t5_rst_err", 32'(ec_a), 0);
    check("t5_rst_locked", 32'(lk_a), 0); check("t5_rst_sticky", 32'(es_a), 0);
    drive(4'b0100); drive(4'b1000); check("t5_relock", 32'(lk_a), 1);

    // 6. error saturation
    do_rst();
    repeat (5) begin drive(4'b0001); drive(4'b0010); drive(4'b0000); end
    check("t6_err5", 32'(ec_a), 5); check("t6_err_sat", 32'(ec_b), 3);

    // random traffic: mostly legal rotation with stalls, skips, junk, clears and resets
    begin
      int cur = 0;
      for (int n = 0; n < 3000; n++) begin
        int r = $urandom_range(0, 99);
        logic [W-1:0] q;
        if (r < 80)      begin cur = (cur + 1) % W; q = 4'(1 << cur); end
        else if (r < 85) q = 4'(1 << cur);
        else if (r < 92) begin cur = $urandom_range(0, W-1); q = 4'(1 << cur); end
        else             q = 4'($urandom_range(0, 15));
        drive(q, ($urandom_range(0, 49) == 0), ($urandom_range(0, 399) == 0));
      end
    end

    drive(4'b0000);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/ring_counter_monitor.md
Name: ring_counter_monitor

Overview:
Receive-side checker for the one-hot ring counter. It samples the counter's q bus every clock, decodes the hot bit to a binary index and locks onto the rotation sequence. It then flags any illegal code, skip or stall. Sits beside the ring counter in sequential-circuit benches and designs as a self-checking consumer of its output.

Parameters:
WIDTH, 4, number of ring stages (width of q_in), ≥2
IDX_W, 2, index width, must equal clog2(WIDTH)
CNT_W, 8, width of wrap_count and err_count (saturating)

Ports:
clk  input  1  rising-edge clock, same clock as the ring counter
rst  input  1  synchronous, active-high reset
q_in  input  WIDTH  ring counter output, sampled every rising edge
clr_err  input  1  synchronous clear of err_sticky and err_count
idx  output  IDX_W  position of the hot bit in the last one-hot sample
idx_valid  output  1  last sample was exactly one-hot
locked  output  1  monitor is tracking the rotation sequence
err_pulse  output  1  one-cycle pulse on a sequence violation while locked
err_sticky  output  1  set by err_pulse, held until clr_err or rst
wrap_count  output  CNT_W  locked wraps of idx WIDTH-1 -> 0, saturating
err_count  output  CNT_W  sequence violations, saturating

Behaviour:
- Clock and reset: one clock, clk. rst is synchronous and active-high. While rst=1, q_in is ignored.
- Reset values: idx=0, idx_valid=0, locked=0, err_pulse=0, err_sticky=0, wrap_count=0, err_count=0, state=HUNT, expected=0.
- Outputs: all registered. A sample on edge N is reflected on the outputs after edge N, giving a latency of 1 cycle.
- Rotation: the next legal code is rotl(prev) = {prev[WIDTH-2:0], prev[WIDTH-1]}. In index terms, idx increments and wraps from WIDTH-1 to 0.
- Decode:
  - one_hot = exactly one bit of q_in set.
  - If one_hot: idx <= position of the set bit, idx_valid <= 1.
  - Otherwise: idx holds its value, idx_valid <= 0.
- FSM states: HUNT, CHECK, LOCKED.
  - HUNT:
    - one_hot: expected <= rotl(q_in), go to CHECK.
    - Otherwise: stay in HUNT.
    - No errors are counted in HUNT.
  - CHECK:
    - q_in == expected: expected <= rotl(q_in), go to LOCKED. locked <= 1 on this same edge.
    - q_in one_hot but != expected: expected <= rotl(q_in), stay in CHECK (re-capture).
    - Not one_hot: go to HUNT.
    - No errors are counted in CHECK.
  - LOCKED:
    - q_in == expected: expected <= rotl(q_in), stay in LOCKED. If idx goes WIDTH-1 -> 0, wrap_count += 1.
    - Any mismatch (illegal code, skip, stall, reverse): err_pulse <= 1 for one cycle, err_sticky <= 1, err_count += 1, locked <= 0.
      - If q_in is one_hot: expected <= rotl(q_in), go to CHECK.
      - Otherwise: go to HUNT.
- Saturation: wrap_count and err_count stop at 2^CNT_W-1 and never roll over to 0.
- clr_err:
  - Clears err_sticky and err_count on the next edge.
  - Does not affect wrap_count, locked or the FSM state.
  - If an error occurs in the same cycle as clr_err, the error wins: err_sticky=1, err_count=1.
- Reset mid-operation: every register returns to its reset value on the next edge, whatever the state or counts. The monitor re-hunts after rst deasserts.
- No combinational path from q_in to any output.

Decomposition:
- Package ring_counter_pkg holds:
  - state enum {HUNT, CHECK, LOCKED}
  - default WIDTH constant
  - rotl and onehot-to-index functions, shared with the ring counter and its bench
- Sub-module ring_onehot_decode: combinational, parameterised by WIDTH. Outputs one_hot and idx.
- FSM, counters and error logic stay in the top module.

Test Plan:
Defaults WIDTH=4, CNT_W=8 unless stated.
1. Lock and wrap: rst for 1 cycle, then q_in = 0001, 0010, 0100, 1000, 0001 on consecutive edges -> idx = 0, 1, 2, 3, 0. locked=1 after the second sample. wrap_count=1 after the fifth. err_count=0.
2. Idle/illegal while hunting: q_in=0000 for 5 cycles, then 0110 for 2 cycles -> locked=0, idx_valid=0, err_pulse never asserts, err_count=0.
3. Violations while locked, each from a freshly locked state with current code 0010:
   - illegal 0101 -> err_pulse for 1 cycle, err_count +1, err_sticky=1, locked=0, state HUNT.
   - skip to 1000 -> error, state CHECK.
   - stall 0010 repeated -> error.
   - A following legal pair (1000 after 0100) re-locks.
4. clr_err: err_count=3, err_sticky=1; pulse clr_err -> both 0 next cycle, wrap_count unchanged. clr_err in the same cycle as a violation -> err_count=1, err_sticky=1.
5. Reset mid-lock: locked, wrap_count=5, err_count=2; rst high for 1 cycle -> all outputs at reset values next edge. A legal sequence afterwards re-locks in 2 samples.
6. Saturation, with CNT_W=2: run 5 full rotations -> wrap_count sticks at 3. Inject 5 violations -> err_count sticks at 3.
